// File: rtl/id_rename.sv
// Rename/operand-capture stage: RAT, ROB tag allocator and a registered issue slot
// that resolves sources from the register file, commit/CDB bypass or ROB lookup.
module id_rename #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NREG      = 32,
    parameter int unsigned ROB_DEPTH = 16,
    parameter int unsigned TAG_W     = $clog2(ROB_DEPTH),
    parameter int unsigned WB_NUM    = 2,
    parameter int unsigned PAYLOAD_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [$clog2(NREG)-1:0]   in_rs1,
    input  logic [$clog2(NREG)-1:0]   in_rs2,
    input  logic [$clog2(NREG)-1:0]   in_rd,
    input  logic                      in_rs1_en,
    input  logic                      in_rs2_en,
    input  logic                      in_rd_en,
    input  logic                      in_pc_en,
    input  logic                      in_imm_en,
    input  logic [XLEN-1:0]           in_pc,
    input  logic [XLEN-1:0]           in_imm,
    input  logic [PAYLOAD_W-1:0]      in_payload,
    input  logic [WB_NUM-1:0]         cdb_valid,
    input  logic [WB_NUM*TAG_W-1:0]   cdb_tag,
    input  logic [WB_NUM*XLEN-1:0]    cdb_data,
    output logic [2*TAG_W-1:0]        rob_q_tag,
    input  logic [1:0]                rob_q_ready,
    input  logic [2*XLEN-1:0]         rob_q_data,
    input  logic                      commit_valid,
    input  logic [TAG_W-1:0]          commit_tag,
    input  logic [$clog2(NREG)-1:0]   commit_rd,
    input  logic [XLEN-1:0]           commit_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [TAG_W-1:0]          out_tag,
    output logic [XLEN-1:0]           out_src1_val,
    output logic [XLEN-1:0]           out_src2_val,
    output logic                      out_src1_busy,
    output logic                      out_src2_busy,
    output logic [TAG_W-1:0]          out_src1_tag,
    output logic [TAG_W-1:0]          out_src2_tag,
    output logic                      out_rd_en,
    output logic [$clog2(NREG)-1:0]   out_rd,
    output logic [PAYLOAD_W-1:0]      out_payload
);
    localparam int unsigned RIDX_W = $clog2(NREG);
    localparam int unsigned CNT_W  = TAG_W + 1;

    logic [XLEN-1:0]   regfile [NREG];
    logic [NREG-1:0]   rat_busy;
    logic [TAG_W-1:0]  rat_tag [NREG];
    logic [TAG_W-1:0]  alloc_ptr;
    logic [CNT_W-1:0]  count;
    logic              accept;

    logic [RIDX_W-1:0] src_idx [2];
    logic              src_en [2];
    logic              src_sub [2];
    logic [XLEN-1:0]   src_sub_val [2];
    logic [XLEN:0]     src_cdb [2];
    logic [XLEN-1:0]   src_val [2];
    logic              src_busy [2];
    logic [TAG_W-1:0]  src_tag [2];
    logic [XLEN:0]     snoop1;
    logic [XLEN:0]     snoop2;

    // {hit, data} of the lowest-numbered valid CDB channel carrying the tag
    function automatic logic [XLEN:0] cdb_match(input logic [TAG_W-1:0] tag);
        logic [XLEN:0] r;
        r = '0;
        for (int k = int'(WB_NUM) - 1; k >= 0; k--) begin
            if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == tag)
                r = {1'b1, cdb_data[k*XLEN +: XLEN]};
        end
        return r;
    endfunction

    assign in_ready = !flush && (count != CNT_W'(ROB_DEPTH)) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    assign src_idx[0]     = in_rs1;
    assign src_idx[1]     = in_rs2;
    assign src_en[0]      = in_rs1_en;
    assign src_en[1]      = in_rs2_en;
    assign src_sub[0]     = in_pc_en;
    assign src_sub[1]     = in_imm_en;
    assign src_sub_val[0] = in_pc;
    assign src_sub_val[1] = in_imm;

    assign rob_q_tag = {rat_tag[in_rs2], rat_tag[in_rs1]};

    // Source resolution against the pre-accept RAT state
    always_comb begin : resolve
        for (int s = 0; s < 2; s++) begin
            src_val[s]  = '0;
            src_busy[s] = 1'b0;
            src_tag[s]  = '0;
            src_cdb[s]  = cdb_match(rat_tag[src_idx[s]]);
            if (src_sub[s]) begin
                src_val[s] = src_sub_val[s];
            end else if (!src_en[s] || src_idx[s] == '0) begin
                src_val[s] = '0;
            end else if (!rat_busy[src_idx[s]]) begin
                src_val[s] = regfile[src_idx[s]];
            end else if (commit_valid && commit_tag == rat_tag[src_idx[s]]) begin
                src_val[s] = commit_data;
            end else if (src_cdb[s][XLEN]) begin
                src_val[s] = src_cdb[s][XLEN-1:0];
            end else if (rob_q_ready[s]) begin
                src_val[s] = rob_q_data[s*XLEN +: XLEN];
            end else begin
                src_busy[s] = 1'b1;
                src_tag[s]  = rat_tag[src_idx[s]];
            end
        end
    end

    always_comb begin : hold_snoop
        snoop1 = cdb_match(out_src1_tag);
        snoop2 = cdb_match(out_src2_tag);
    end

    // RAT, register file and ROB occupancy; a same-rd accept overrides the commit clear
    always_ff @(posedge clk or posedge rst) begin : rename_state
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regfile[i] <= '0;
                rat_tag[i] <= '0;
            end
            rat_busy  <= '0;
            alloc_ptr <= '0;
            count     <= '0;
        end else if (flush) begin
            rat_busy  <= '0;
            alloc_ptr <= '0;
            count     <= '0;
        end else begin
            if (commit_valid && commit_rd != '0) begin
                regfile[commit_rd] <= commit_data;
                if (rat_tag[commit_rd] == commit_tag)
                    rat_busy[commit_rd] <= 1'b0;
            end
            if (accept) begin
                if (in_rd_en && in_rd != '0) begin
                    rat_busy[in_rd] <= 1'b1;
                    rat_tag[in_rd]  <= alloc_ptr;
                end
                alloc_ptr <= alloc_ptr + TAG_W'(1);
            end
            count <= count + CNT_W'(accept) - CNT_W'(commit_valid);
        end
    end

    // Issue slot: load on accept, otherwise keep capturing CDB results while stalled
    always_ff @(posedge clk or posedge rst) begin : out_slot
        if (rst) begin
            out_valid     <= 1'b0;
            out_tag       <= '0;
            out_src1_val  <= '0;
            out_src2_val  <= '0;
            out_src1_busy <= 1'b0;
            out_src2_busy <= 1'b0;
            out_src1_tag  <= '0;
            out_src2_tag  <= '0;
            out_rd_en     <= 1'b0;
            out_rd        <= '0;
            out_payload   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_tag       <= alloc_ptr;
            out_src1_val  <= src_val[0];
            out_src2_val  <= src_val[1];
            out_src1_busy <= src_busy[0];
            out_src2_busy <= src_busy[1];
            out_src1_tag  <= src_tag[0];
            out_src2_tag  <= src_tag[1];
            out_rd_en     <= in_rd_en;
            out_rd        <= in_rd;
            out_payload   <= in_payload;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else if (out_valid) begin
            if (out_src1_busy && snoop1[XLEN]) begin
                out_src1_val  <= snoop1[XLEN-1:0];
                out_src1_busy <= 1'b0;
            end
            if (out_src2_busy && snoop2[XLEN]) begin
                out_src2_val  <= snoop2[XLEN-1:0];
                out_src2_busy <= 1'b0;
            end
        end
    end

    // Retiring from an empty ROB is a protocol violation by the ROB
    always_ff @(posedge clk) begin : commit_check
        if (!rst && !flush && commit_valid)
            assert (count != '0);
    end
endmodule

// File: tb/tb_id_rename.sv
// Bench for id_rename: directed scenarios plus random traffic, every cycle compared
// against a queue/array reference model of the rename stage.
module tb_id_rename;
    typedef struct {
        logic [3:0] tag;
        logic [4:0] rd;
    } rob_e_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_rs1_en, in_rs2_en, in_rd_en, in_pc_en, in_imm_en;
    logic [31:0] in_pc, in_imm;
    logic [15:0] in_payload;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_data;
    logic [7:0]  rob_q_tag;
    logic [1:0]  rob_q_ready;
    logic [63:0] rob_q_data;
    logic        commit_valid;
    logic [3:0]  commit_tag;
    logic [4:0]  commit_rd;
    logic [31:0] commit_data;
    logic        out_valid, out_ready;
    logic [3:0]  out_tag, out_src1_tag, out_src2_tag;
    logic [31:0] out_src1_val, out_src2_val;
    logic        out_src1_busy, out_src2_busy, out_rd_en;
    logic [4:0]  out_rd;
    logic [15:0] out_payload;

    id_rename dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_en(in_rs1_en), .in_rs2_en(in_rs2_en), .in_rd_en(in_rd_en),
        .in_pc_en(in_pc_en), .in_imm_en(in_imm_en),
        .in_pc(in_pc), .in_imm(in_imm), .in_payload(in_payload),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .rob_q_tag(rob_q_tag), .rob_q_ready(rob_q_ready), .rob_q_data(rob_q_data),
        .commit_valid(commit_valid), .commit_tag(commit_tag),
        .commit_rd(commit_rd), .commit_data(commit_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_src1_val(out_src1_val), .out_src2_val(out_src2_val),
        .out_src1_busy(out_src1_busy), .out_src2_busy(out_src2_busy),
        .out_src1_tag(out_src1_tag), .out_src2_tag(out_src2_tag),
        .out_rd_en(out_rd_en), .out_rd(out_rd), .out_payload(out_payload)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_rf [32];
    bit          m_busy [32];
    logic [3:0]  m_rtag [32];
    int          m_count, m_alloc;
    rob_e_t      m_rob [$];
    bit          m_ov;
    logic [3:0]  m_otag;
    logic [31:0] m_val [2];
    bit          m_sbusy [2];
    logic [3:0]  m_stag [2];
    bit          m_rd_en;
    logic [4:0]  m_rd;
    logic [15:0] m_pay;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_rf[i] = '0; m_busy[i] = 0; m_rtag[i] = '0;
        end
        m_count = 0; m_alloc = 0; m_rob.delete();
        m_ov = 0; m_otag = '0; m_rd_en = 0; m_rd = '0; m_pay = '0;
        for (int s = 0; s < 2; s++) begin
            m_val[s] = '0; m_sbusy[s] = 0; m_stag[s] = '0;
        end
    endtask

    task automatic idle();
        flush = 0; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_rs1_en = 0; in_rs2_en = 0; in_rd_en = 0; in_pc_en = 0; in_imm_en = 0;
        in_pc = 0; in_imm = 0; in_payload = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
        rob_q_ready = 0; rob_q_data = 0;
        commit_valid = 0; commit_tag = 0; commit_rd = 0; commit_data = 0;
        out_ready = 1;
    endtask

    // Retire the oldest in-flight instruction (if any) with the given result
    task automatic set_commit(input logic [31:0] d);
        if (m_rob.size() > 0) begin
            commit_valid = 1; commit_tag = m_rob[0].tag;
            commit_rd = m_rob[0].rd; commit_data = d;
        end else begin
            commit_valid = 0;
        end
    endtask

    task automatic cdb_find(input logic [3:0] t, output bit hit, output logic [31:0] d);
        hit = 0; d = '0;
        for (int k = 0; k < 2; k++)
            if (!hit && cdb_valid[k] && cdb_tag[k*4 +: 4] == t) begin
                hit = 1; d = cdb_data[k*32 +: 32];
            end
    endtask

    task automatic resolve(input int s, output logic [31:0] v, output bit b, output logic [3:0] t);
        bit sub, en, hit;
        logic [31:0] sv, d;
        logic [4:0] idx;
        sub = (s == 0) ? in_pc_en : in_imm_en;
        sv  = (s == 0) ? in_pc : in_imm;
        en  = (s == 0) ? in_rs1_en : in_rs2_en;
        idx = (s == 0) ? in_rs1 : in_rs2;
        v = '0; b = 0; t = '0;
        if (sub) v = sv;
        else if (en && idx != 0) begin
            if (!m_busy[idx]) v = m_rf[idx];
            else begin
                cdb_find(m_rtag[idx], hit, d);
                if (commit_valid && commit_tag == m_rtag[idx]) v = commit_data;
                else if (hit) v = d;
                else if (rob_q_ready[s]) v = rob_q_data[s*32 +: 32];
                else begin b = 1; t = m_rtag[idx]; end
            end
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, m_ov);
        chk("out_tag", out_tag, m_otag);
        chk("src1_val", out_src1_val, m_val[0]);
        chk("src2_val", out_src2_val, m_val[1]);
        chk("src1_busy", out_src1_busy, m_sbusy[0]);
        chk("src2_busy", out_src2_busy, m_sbusy[1]);
        chk("src1_tag", out_src1_tag, m_stag[0]);
        chk("src2_tag", out_src2_tag, m_stag[1]);
        chk("rd_en", out_rd_en, m_rd_en);
        chk("rd", out_rd, m_rd);
        chk("payload", out_payload, m_pay);
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs
    task automatic tick();
        logic [31:0] v [2];
        bit b [2];
        logic [3:0] t [2];
        bit ready, acc, hit;
        logic [31:0] d;
        rob_e_t e;
        #1;
        ready = !flush && m_count != 16 && (!m_ov || out_ready);
        chk("in_ready", in_ready, ready);
        chk("rob_q_tag", rob_q_tag, {m_rtag[in_rs2], m_rtag[in_rs1]});
        resolve(0, v[0], b[0], t[0]);
        resolve(1, v[1], b[1], t[1]);
        acc = in_valid && ready;
        if (flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
            m_count = 0; m_alloc = 0; m_rob.delete(); m_ov = 0;
        end else begin
            if (commit_valid) begin
                e = m_rob.pop_front();
                if (commit_rd != 0) begin
                    m_rf[commit_rd] = commit_data;
                    if (m_rtag[commit_rd] == commit_tag) m_busy[commit_rd] = 0;
                end
                m_count--;
            end
            if (acc) begin
                if (in_rd_en && in_rd != 0) begin
                    m_busy[in_rd] = 1; m_rtag[in_rd] = 4'(m_alloc);
                end
                m_rob.push_back('{tag: 4'(m_alloc), rd: (in_rd_en ? in_rd : 5'd0)});
                m_ov = 1; m_otag = 4'(m_alloc);
                for (int s = 0; s < 2; s++) begin
                    m_val[s] = v[s]; m_sbusy[s] = b[s]; m_stag[s] = t[s];
                end
                m_rd_en = in_rd_en; m_rd = in_rd; m_pay = in_payload;
                m_alloc = (m_alloc + 1) % 16;
                m_count++;
            end else if (m_ov && out_ready) begin
                m_ov = 0;
            end else if (m_ov) begin
                for (int s = 0; s < 2; s++)
                    if (m_sbusy[s]) begin
                        cdb_find(m_stag[s], hit, d);
                        if (hit) begin m_val[s] = d; m_sbusy[s] = 0; end
                    end
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic rand_cycle();
        idle();
        in_valid = $urandom_range(0, 3) != 0;
        in_rs1 = 5'($urandom_range(0, 7)); in_rs2 = 5'($urandom_range(0, 7));
        in_rd = 5'($urandom_range(0, 7));
        in_rs1_en = 1'($urandom); in_rs2_en = 1'($urandom); in_rd_en = 1'($urandom);
        in_pc_en = $urandom_range(0, 3) == 0; in_imm_en = $urandom_range(0, 3) == 0;
        in_pc = $urandom; in_imm = $urandom; in_payload = 16'($urandom);
        cdb_valid = 2'($urandom);
        for (int k = 0; k < 2; k++) begin
            cdb_tag[k*4 +: 4] = (m_rob.size() > 0) ?
                m_rob[$urandom_range(0, m_rob.size() - 1)].tag : 4'($urandom);
            cdb_data[k*32 +: 32] = $urandom;
        end
        rob_q_ready = 2'($urandom);
        rob_q_data = {$urandom, $urandom};
        if ($urandom_range(0, 2) == 0) set_commit($urandom);
        out_ready = $urandom_range(0, 3) != 0;
        flush = $urandom_range(0, 63) == 0;
        tick();
    endtask

    initial begin
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_src1_val", out_src1_val, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 0;

        // x1 = x0 + 5, then a consumer of x1
        idle(); in_valid = 1; in_rs1_en = 1; in_imm_en = 1; in_imm = 5;
        in_rd = 1; in_rd_en = 1;
        tick();
        chk("t1_tag", out_tag, 0);
        chk("t1_src2_val", out_src2_val, 5);
        chk("t1_src2_busy", out_src2_busy, 0);
        idle(); in_valid = 1; in_rs1 = 1; in_rs1_en = 1;
        #1 chk("t1_rob_q_tag", rob_q_tag[3:0], 0);
        tick();
        chk("t1_src1_busy", out_src1_busy, 1);
        chk("t1_src1_tag", out_src1_tag, 0);

        // Stalled slot captures CDB channel 1
        idle(); flush = 1; tick();
        idle(); in_valid = 1;
        repeat (3) tick();
        in_rd = 9; in_rd_en = 1; tick();
        idle(); in_valid = 1; in_rs1 = 9; in_rs1_en = 1; in_payload = 16'hA5A5; tick();
        idle(); out_ready = 0; cdb_valid = 2'b10; cdb_tag = {4'd3, 4'd0};
        cdb_data = {32'hDEAD, 32'h0}; tick();
        chk("hold_src1_val", out_src1_val, 32'hDEAD);
        chk("hold_src1_busy", out_src1_busy, 0);
        chk("hold_payload", out_payload, 16'hA5A5);
        idle(); out_ready = 0; tick();

        // Fill the ROB, commit one, tag wraps
        idle(); flush = 1; tick();
        idle(); in_valid = 1;
        repeat (16) tick();
        chk("full_in_ready", in_ready, 0);
        set_commit(32'h1111);
        #1 chk("full_commit_ready", in_ready, 0);
        tick();
        idle(); in_valid = 1;
        #1 chk("freed_in_ready", in_ready, 1);
        tick();
        chk("wrap_tag", out_tag, 0);

        // Commit x2 (tag 4) while a new producer of x2 is accepted
        idle(); flush = 1; tick();
        idle(); in_valid = 1;
        repeat (4) tick();
        in_rd = 2; in_rd_en = 1; tick();
        for (int i = 0; i < 4; i++) begin
            idle(); set_commit(32'h0); tick();
        end
        idle(); set_commit(32'h1234_5678); in_valid = 1; in_rd = 2; in_rd_en = 1; tick();
        idle(); in_valid = 1; in_rs1 = 2; in_rs1_en = 1; tick();
        chk("same_rd_busy", out_src1_busy, 1);
        chk("same_rd_tag", out_src1_tag, 5);

        // ROB lookup, then CDB taking priority over the ROB
        idle(); in_valid = 1; in_rd = 3; in_rd_en = 1; tick();
        idle(); in_valid = 1; in_rs1 = 3; in_rs1_en = 1;
        rob_q_ready = 2'b01; rob_q_data = {32'h0, 32'h42}; tick();
        chk("rob_val", out_src1_val, 32'h42);
        chk("rob_busy", out_src1_busy, 0);
        idle(); in_valid = 1; in_rs1 = 3; in_rs1_en = 1;
        rob_q_ready = 2'b01; rob_q_data = {32'h0, 32'h42};
        cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd7}; cdb_data = {32'h0, 32'h77}; tick();
        chk("cdb_over_rob", out_src1_val, 32'h77);

        // Flush with a valid slot and 7 in flight
        idle(); flush = 1; tick();
        for (int i = 1; i <= 7; i++) begin
            idle(); in_valid = 1; in_rd = 5'(i); in_rd_en = 1; tick();
        end
        idle(); flush = 1; in_valid = 1; set_commit(32'h5); tick();
        chk("flush_out_valid", out_valid, 0);
        idle(); in_valid = 1; in_rs1 = 1; in_rs1_en = 1; tick();
        chk("flush_next_tag", out_tag, 0);
        chk("flush_rat_clear", out_src1_busy, 0);

        repeat (3000) rand_cycle();

        // Asynchronous reset in the middle of traffic
        in_valid = 1;
        #2 rst = 1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_tag", out_tag, 0);
        chk("midrst_in_ready", in_ready, 1);
        idle();
        @(posedge clk);
        #1 rst = 0;
        model_reset();
        repeat (300) rand_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/id_rename.md
Name: id_rename

Overview:
- Parametrised successor to the single-issue decode/operand stage: register alias table (RAT), ROB tag allocator and operand-capture stage for the Tomasulo core.
- Accepts one decoded instruction per cycle from the decoder and renames rd to a freshly allocated ROB tag.
- Resolves each source operand from the committed register file, multi-channel CDB bypass or ROB lookup.
- Presents the result in a registered output slot that keeps snooping the CDB while stalled by issue.

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, architectural registers; x0 is hard-wired to zero.
- ROB_DEPTH, 16, ROB entries; must be a power of two.
- TAG_W, $clog2(ROB_DEPTH), ROB tag width.
- WB_NUM, 2, CDB broadcast channels.
- PAYLOAD_W, 16, opaque op/ex_unit/width bits passed through unchanged.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  synchronous squash of all in-flight state (mispredict from ROB).
- in_valid / in_ready  in/out  1  decoder handshake; transfer occurs when both are high.
- in_rs1, in_rs2, in_rd  in  $clog2(NREG)  register indices.
- in_rs1_en, in_rs2_en, in_rd_en  in  1  operand-used flags and rd-written flag.
- in_pc_en, in_imm_en  in  1  substitute in_pc for src1, in_imm for src2.
- in_pc, in_imm  in  XLEN  PC and sign-extended immediate.
- in_payload  in  PAYLOAD_W  passthrough bits.
- cdb_valid  in  WB_NUM  per-channel broadcast valid.
- cdb_tag  in  WB_NUM*TAG_W  packed broadcast tags.
- cdb_data  in  WB_NUM*XLEN  packed broadcast data.
- rob_q_tag  out  2*TAG_W  combinational ROB lookup tags, one per source.
- rob_q_ready  in  2  ROB entry holds a result.
- rob_q_data  in  2*XLEN  ROB entry results.
- commit_valid  in  1  one ROB retirement this cycle.
- commit_tag  in  TAG_W  retiring tag.
- commit_rd  in  $clog2(NREG)  retiring destination.
- commit_data  in  XLEN  retiring value.
- out_valid / out_ready  out/in  1  issue handshake.
- out_tag  out  TAG_W  allocated ROB tag.
- out_src1_val, out_src2_val  out  XLEN  operand values.
- out_src1_busy, out_src2_busy  out  1  operand still pending.
- out_src1_tag, out_src2_tag  out  TAG_W  awaited producer tag.
- out_rd_en, out_rd, out_payload  out  -  forwarded from the input.

Behaviour:
- Reset (async):
  - Register file = 0.
  - All RAT busy bits = 0.
  - alloc_ptr = 0, count = 0.
  - out_valid = 0; all out_* data = 0.
- in_ready = !flush && count != ROB_DEPTH && (!out_valid || out_ready).
  - in_ready uses the registered count; a same-cycle commit does not free a slot until the next cycle.
- Accept (in_valid && in_ready):
  - out_tag <= alloc_ptr; alloc_ptr increments mod ROB_DEPTH (wraps 15->0 at default).
  - The output slot loads in the same edge, giving 1-cycle latency.
- Count update: count <= count + accept - commit_valid.
  - commit_valid with count == 0 is illegal; assert it in simulation.
- RAT write on accept with in_rd_en && in_rd != 0: busy[rd] <= 1, tag[rd] <= alloc_ptr.
- Commit:
  - regfile[commit_rd] <= commit_data when commit_rd != 0.
  - busy[commit_rd] clears only if tag[commit_rd] == commit_tag.
  - A same-cycle accept writing the same rd wins; busy stays set with the new tag.
- Source resolution, per source, first match wins:
  - pc_en (src1) or imm_en (src2) -> that value, busy = 0.
  - Source disabled or index 0 -> value 0, busy = 0.
  - RAT not busy -> regfile value.
  - Busy and commit_valid && commit_tag == tag -> commit_data.
  - Busy and any cdb_valid[k] with matching tag -> that channel's data; the lowest k wins if several match.
  - Busy and rob_q_ready -> rob_q_data.
  - Otherwise busy = 1, tag = RAT tag, value = 0.
  - rob_q_tag always drives the RAT tag of the corresponding source.
- Source reads use the RAT state from before this cycle's accept, so rd == rs1 reads the old mapping.
- Holding (out_valid && !out_ready):
  - Each cycle, a busy source whose tag matches any valid CDB channel captures the data and clears busy.
  - All other fields are stable.
- out_valid clears after the out_ready handshake unless a new accept occurs.
- flush has top priority:
  - Clears all RAT busy bits, alloc_ptr, count and out_valid.
  - The register file is unchanged; an accept or commit in the flush cycle is ignored.
- Reset mid-operation returns to the reset state immediately, whatever handshake is in progress.

Test Plan:
- After reset, dispatch x1 = x0 + imm 5 with rd = 1 -> out_tag 0, src2_val 5, busy 0. Then dispatch rs1 = 1 -> src1_busy 1, tag 0, rob_q_tag 0.
- Hold out_ready = 0 with src1 busy on tag 3, drive cdb channel 1 with tag 3, data 0xDEAD -> next cycle src1_busy 0, val 0xDEAD; other fields unchanged.
- Dispatch 16 instructions, no commits -> in_ready = 0 at count 16. A commit lowers count to 15; in_ready rises the following cycle; the next out_tag wraps to 0.
- Commit x2 with tag 4 while accepting a new rd = 2 in the same cycle -> RAT x2 busy with the new tag; regfile x2 = commit_data.
- Busy source with rob_q_ready = 1, data 0x42 -> src val 0x42, busy 0. Same tag also on the CDB with data 0x77 -> CDB wins, val 0x77.
- flush while out_valid = 1 and count = 7 -> next cycle out_valid 0, count 0, all RAT busy 0, next out_tag 0.
